mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 clock  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ex_valid  in  1  EX/MEM register holds a valid operation.
REQ-004 ex_mem_instruction  in  32  operation word: [31:30] class (01 load, 10 store, other non-memory), [29] width (0 byte, 1 pair).
REQ-005 ex_mem_data_top / ex_mem_data_bot  in  8 each  execute result; {top,bot} is the address for memory ops, pass-through data otherwise.
REQ-006 ex_mem_str_top / ex_mem_str_bot  in  8 each  store data from the pipeline register.
REQ-007 mem_str_data_sel_top / mem_str_data_sel_bot  in  5 each  store-data forwarding select: 0 pipeline, 1 mem_wb data, 2 last loaded data, others pipeline.
REQ-008 mem_wb_data_top / mem_wb_data_bot  in  8 each  MEM/WB forwarding data.
REQ-009 mem_req, mem_we  out  1 each  bus request and write enable.
REQ-010 mem_addr  out  16  bus address.
REQ-011 mem_wdata  out  8  bus write data.
REQ-012 mem_rdata, mem_ack  in  8, 1  bus read data and single-cycle acknowledge.
REQ-013 stall  out  1  upstream holds EX/MEM contents while high.
REQ-014 wb_valid, wb_instruction, wb_data_top, wb_data_bot  out  1, 32, 8, 8  registered MEM/WB outputs.

Function
REQ-015 FSM states: IDLE, TOP, BOT, DONE.
REQ-016 IDLE with ex_valid and non-memory class: register the instruction and data onto the wb outputs, wb_valid=1 next cycle (latency 1), no bus activity.
REQ-017 IDLE with ex_valid and memory class: latch instruction, address and forwarded store data; next state TOP for pair width, BOT for byte width.
REQ-018 stall = (IDLE & ex_valid & memory class) | TOP | BOT; low in DONE and otherwise.
REQ-019 TOP: mem_req=1, mem_addr=address, top byte; BOT: mem_req=1, mem_addr=address+1 for pair (wraps 0xFFFF->0x0000) or address for byte, bottom byte.
REQ-020 mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack; advance only on a mem_ack cycle.
REQ-021 Load: capture mem_rdata into the byte of the current beat on ack; byte loads set wb_data_top to 0x00.
REQ-022 Store: mem_we=1, mem_wdata = forwarded byte for the beat; wb_data = stored bytes.
REQ-023 Final ack: load wb registers and the last-loaded register, enter DONE; DONE: wb_valid=1 for exactly one cycle, no new acceptance, then IDLE.
REQ-024 mem_ack outside TOP/BOT is ignored.
REQ-025 ex_valid low in IDLE: wb_valid=0 next cycle; wb data retains its previous value.

Reset
REQ-026 Reset forces IDLE; mem_req, mem_we, stall, wb_valid = 0; mem_addr, mem_wdata, wb data, wb_instruction, last-loaded = 0.
REQ-027 Reset mid-access abandons the access; the in-flight result is never written back.

Configuration
REQ-028 MEM_ACCESS_TIMEOUT_EN defined: 4-bit counter per beat; 16 cycles in TOP/BOT without ack abort to DONE with wb_valid=1, wb data 0x00, sticky output mem_fault=1 until reset.
REQ-029 MEM_ACCESS_TIMEOUT_EN undefined: no counter, no mem_fault port; a beat waits indefinitely.

Structure
REQ-030 Shared package holds class encodings, width bit position, forwarding-select codes, FSM state encoding and timeout limit.
REQ-031 One sub-module, store_data_fwd_mux: combinational store-data select per REQ-007.

Verification
REQ-032 Non-memory op, data 0x12/0x34 -> next cycle wb_valid=1, wb_data 0x12/0x34, stall never high.
REQ-033 Pair load at 0x1000, ack after 2 cycles each, rdata 0xAB then 0xCD -> addrs 0x1000 then 0x1001, stall high until the second ack, wb_data 0xAB/0xCD in DONE.
REQ-034 Pair store at 0xFFFF, sel=1, mem_wb 0x55/0x66 -> writes 0x55@0xFFFF, 0x66@0x0000.
REQ-035 Byte load followed by store with sel_bot=2 -> stored byte equals the loaded byte.
REQ-036 Reset asserted in TOP -> next cycle mem_req=0, stall=0, wb_valid=0; stray ack ignored.
REQ-037 With MEM_ACCESS_TIMEOUT_EN, no ack -> abort after 16 cycles, mem_fault=1, wb_valid pulse with data 0x00.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory access stage: instruction field layout,
// forwarding select codes, FSM encoding and the bus timeout limit.
package mem_access_stage_pkg;

  localparam logic [1:0] CLASS_LOAD  = 2'b01;
  localparam logic [1:0] CLASS_STORE = 2'b10;
  localparam int         WIDTH_BIT   = 29;

  localparam logic [4:0] FWD_SEL_PIPE      = 5'd0;
  localparam logic [4:0] FWD_SEL_MEM_WB    = 5'd1;
  localparam logic [4:0] FWD_SEL_LAST_LOAD = 5'd2;

  localparam int TIMEOUT_LIMIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TOP  = 2'd1,
    ST_BOT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_mem_class(input logic [31:0] instr);
    return (instr[31:30] == CLASS_LOAD) || (instr[31:30] == CLASS_STORE);
  endfunction

endpackage

// File: rtl/mem_access_stage_store_data_fwd_mux.sv
// Per-byte store-data forwarding select: pipeline register, MEM/WB data or
// the most recently loaded byte. Unknown select codes fall back to pipeline.
module store_data_fwd_mux
  import mem_access_stage_pkg::*;
(
  input  logic [4:0] sel,
  input  logic [7:0] pipe_data,
  input  logic [7:0] mem_wb_data,
  input  logic [7:0] last_load_data,
  output logic [7:0] fwd_data
);

  always_comb begin
    fwd_data = pipe_data;
    case (sel)
      FWD_SEL_MEM_WB:    fwd_data = mem_wb_data;
      FWD_SEL_LAST_LOAD: fwd_data = last_load_data;
      default:           fwd_data = pipe_data;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs byte/pair loads and stores as one or two bus beats
// and registers the MEM/WB outputs. Optional beat timeout: MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_mem_instruction,
  input  logic [7:0]  ex_mem_data_top,
  input  logic [7:0]  ex_mem_data_bot,
  input  logic [7:0]  ex_mem_str_top,
  input  logic [7:0]  ex_mem_str_bot,
  input  logic [4:0]  mem_str_data_sel_top,
  input  logic [4:0]  mem_str_data_sel_bot,
  input  logic [7:0]  mem_wb_data_top,
  input  logic [7:0]  mem_wb_data_bot,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_instruction,
  output logic [7:0]  wb_data_top,
  output logic [7:0]  wb_data_bot,
`ifdef MEM_ACCESS_TIMEOUT_EN
  output logic        mem_fault,
`endif
  output logic [1:0]  fsm_state
);

  // Bus handshake: mem_req/mem_addr/mem_we/mem_wdata are registered and held
  // stable while mem_req is high; a beat completes on the cycle mem_ack is
  // high, and mem_ack is ignored whenever no beat is outstanding.

  state_t      state;
  logic [31:0] instr_q;
  logic [15:0] addr_q;
  logic [7:0]  st_top_q;
  logic [7:0]  st_bot_q;
  logic [7:0]  ld_top_q;
  logic [7:0]  last_top_q;
  logic [7:0]  last_bot_q;
  logic [7:0]  fwd_top;
  logic [7:0]  fwd_bot;
  logic        accept_mem;
  logic        is_store_q;
  logic        is_pair_q;
  logic        new_store;
  logic        new_pair;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [3:0]  tmo_cnt;
`endif

  store_data_fwd_mux u_fwd_top (
    .sel            (mem_str_data_sel_top),
    .pipe_data      (ex_mem_str_top),
    .mem_wb_data    (mem_wb_data_top),
    .last_load_data (last_top_q),
    .fwd_data       (fwd_top)
  );

  store_data_fwd_mux u_fwd_bot (
    .sel            (mem_str_data_sel_bot),
    .pipe_data      (ex_mem_str_bot),
    .mem_wb_data    (mem_wb_data_bot),
    .last_load_data (last_bot_q),
    .fwd_data       (fwd_bot)
  );

  assign accept_mem = (state == ST_IDLE) && ex_valid && is_mem_class(ex_mem_instruction);
  assign new_store  = (ex_mem_instruction[31:30] == CLASS_STORE);
  assign new_pair   = ex_mem_instruction[WIDTH_BIT];
  assign is_store_q = (instr_q[31:30] == CLASS_STORE);
  assign is_pair_q  = instr_q[WIDTH_BIT];

  // Stall covers the accepting cycle so upstream holds until the final ack.
  assign stall     = accept_mem || (state == ST_TOP) || (state == ST_BOT);
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      instr_q        <= '0;
      addr_q         <= '0;
      st_top_q       <= '0;
      st_bot_q       <= '0;
      ld_top_q       <= '0;
      last_top_q     <= '0;
      last_bot_q     <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      wb_valid       <= 1'b0;
      wb_instruction <= '0;
      wb_data_top    <= '0;
      wb_data_bot    <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_cnt        <= '0;
      mem_fault      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_mem) begin
            instr_q   <= ex_mem_instruction;
            addr_q    <= {ex_mem_data_top, ex_mem_data_bot};
            st_top_q  <= fwd_top;
            st_bot_q  <= fwd_bot;
            mem_req   <= 1'b1;
            mem_we    <= new_store;
            mem_addr  <= {ex_mem_data_top, ex_mem_data_bot};
            wb_valid  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            if (new_pair) begin
              state     <= ST_TOP;
              mem_wdata <= new_store ? fwd_top : 8'h00;
            end else begin
              state     <= ST_BOT;
              mem_wdata <= new_store ? fwd_bot : 8'h00;
            end
          end else if (ex_valid) begin
            wb_valid       <= 1'b1;
            wb_instruction <= ex_mem_instruction;
            wb_data_top    <= ex_mem_data_top;
            wb_data_bot    <= ex_mem_data_bot;
          end else begin
            wb_valid <= 1'b0;
          end
        end

        ST_TOP: begin
          if (mem_ack) begin
            ld_top_q  <= mem_rdata;
            state     <= ST_BOT;
            mem_addr  <= addr_q + 16'd1;
            mem_wdata <= is_store_q ? st_bot_q : 8'h00;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt   <= '0;
          end else if (tmo_cnt == 4'(TIMEOUT_LIMIT - 1)) begin
            state          <= ST_DONE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_fault      <= 1'b1;
            wb_valid       <= 1'b1;
            wb_instruction <= instr_q;
            wb_data_top    <= 8'h00;
            wb_data_bot    <= 8'h00;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
`endif
          end
        end

        ST_BOT: begin
          if (mem_ack) begin
            state          <= ST_DONE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            wb_valid       <= 1'b1;
            wb_instruction <= instr_q;
            if (is_store_q) begin
              wb_data_top <= is_pair_q ? st_top_q : 8'h00;
              wb_data_bot <= st_bot_q;
            end else begin
              wb_data_top <= is_pair_q ? ld_top_q : 8'h00;
              wb_data_bot <= mem_rdata;
              last_top_q  <= is_pair_q ? ld_top_q : 8'h00;
              last_bot_q  <= mem_rdata;
            end
`ifdef MEM_ACCESS_TIMEOUT_EN
          end else if (tmo_cnt == 4'(TIMEOUT_LIMIT - 1)) begin
            state          <= ST_DONE;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_fault      <= 1'b1;
            wb_valid       <= 1'b1;
            wb_instruction <= instr_q;
            wb_data_top    <= 8'h00;
            wb_data_bot    <= 8'h00;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
`endif
          end
        end

        ST_DONE: begin
          wb_valid <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
